// File: rtl/inv_cfg_loader.sv
// Inversion-bit config loader: collects per-site writes into a shadow vector, then shifts
// it MSB-first into the site chain and latches. Optional readback check: INV_CFG_READBACK_EN.
module inv_cfg_loader #(
  parameter int unsigned          NUM_SITES = 8,
  parameter int unsigned          IDX_W     = 3,
  parameter logic [NUM_SITES-1:0] INIT      = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  input  logic [IDX_W-1:0]     i_wr_idx,
  input  logic                 i_wr_inv,
  input  logic                 i_commit,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_sdo,
  output logic                 o_cfg_shift,
  output logic                 o_cfg_latch,
  input  logic                 i_cfg_sdi,
  output logic                 o_rb_err,
  output logic [NUM_SITES-1:0] o_shadow,
  output logic [NUM_SITES-1:0] o_active
);

  localparam int unsigned CNT_W = (NUM_SITES > 1) ? $clog2(NUM_SITES) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StLatch} state_t;

  state_t               r_state, w_state_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [NUM_SITES-1:0] r_shadow, w_shadow_d;
  logic [NUM_SITES-1:0] r_active, w_active_d;
  logic [NUM_SITES-1:0] r_sr, w_sr_d;
  logic                 r_wr_ready, w_wr_ready_d;
  logic                 r_busy, w_busy_d;
  logic                 r_latch, w_latch_d;
  logic                 r_shift, w_shift_d;
  logic                 r_sdo, w_sdo_d;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_shadow_d   = r_shadow;
    w_active_d   = r_active;
    w_sr_d       = r_sr;
    w_wr_ready_d = 1'b0;
    w_busy_d     = 1'b0;
    w_latch_d    = 1'b0;
    w_shift_d    = 1'b0;
    w_sdo_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Out-of-range indices match no site and are silently dropped.
        if (i_wr_valid) begin
          for (int i = 0; i < int'(NUM_SITES); i++) begin
            if (i_wr_idx == IDX_W'(i)) w_shadow_d[i] = i_wr_inv;
          end
        end
        if (i_commit) begin
          w_state_d = StShift;
          w_cnt_d   = '0;
          w_sr_d    = w_shadow_d;
          w_busy_d  = 1'b1;
          w_shift_d = 1'b1;
          w_sdo_d   = w_shadow_d[NUM_SITES-1];
        end else begin
          w_wr_ready_d = 1'b1;
        end
      end
      StShift: begin
        // Rotating N times brings the snapshot back in place for the latch cycle.
        w_sr_d   = {r_sr[NUM_SITES-2:0], r_sr[NUM_SITES-1]};
        w_busy_d = 1'b1;
        if (r_cnt == CNT_W'(NUM_SITES - 1)) begin
          w_state_d = StLatch;
          w_latch_d = 1'b1;
        end else begin
          w_cnt_d   = r_cnt + CNT_W'(1);
          w_shift_d = 1'b1;
          w_sdo_d   = r_sr[NUM_SITES-2];
        end
      end
      StLatch: begin
        w_active_d   = r_sr;
        w_state_d    = StIdle;
        w_wr_ready_d = 1'b1;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_shadow   <= INIT;
      r_active   <= INIT;
      r_sr       <= INIT;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_latch    <= 1'b0;
      r_shift    <= 1'b0;
      r_sdo      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_shadow   <= w_shadow_d;
      r_active   <= w_active_d;
      r_sr       <= w_sr_d;
      r_wr_ready <= w_wr_ready_d;
      r_busy     <= w_busy_d;
      r_latch    <= w_latch_d;
      r_shift    <= w_shift_d;
      r_sdo      <= w_sdo_d;
    end
  end

`ifdef INV_CFG_READBACK_EN
  logic w_rb_exp;
  logic r_rb_err;

  // Chain returns old contents MSB first, so shift cycle k checks site NUM_SITES-1-k.
  always_comb begin
    w_rb_exp = 1'b0;
    for (int i = 0; i < int'(NUM_SITES); i++) begin
      if (r_cnt == CNT_W'(int'(NUM_SITES) - 1 - i)) w_rb_exp = r_active[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_err <= 1'b0;
    end else if (r_state == StIdle && i_commit) begin
      r_rb_err <= 1'b0;
    end else if (r_state == StShift && i_cfg_sdi != w_rb_exp) begin
      r_rb_err <= 1'b1;
    end
  end

  assign o_rb_err = r_rb_err;
`else
  logic w_unused_sdi;
  assign w_unused_sdi = i_cfg_sdi;
  assign o_rb_err     = 1'b0;
`endif

  assign o_wr_ready  = r_wr_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_latch;
  assign o_cfg_latch = r_latch;
  assign o_cfg_shift = r_shift;
  assign o_cfg_sdo   = r_sdo;
  assign o_shadow    = r_shadow;
  assign o_active    = r_active;

endmodule

// File: tb/tb_inv_cfg_loader.sv
// Self-checking bench for inv_cfg_loader: per-cycle compare against a timeline model plus
// directed literal checks. Readback expectations follow INV_CFG_READBACK_EN.
module tb_inv_cfg_loader;
  localparam int unsigned N    = 8;
  localparam int unsigned IW   = 4;
  localparam logic [N-1:0] INIT = '0;
`ifdef INV_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic i_wr_valid, i_wr_inv, i_commit, i_cfg_sdi;
  logic [IW-1:0] i_wr_idx;
  logic o_wr_ready, o_busy, o_done, o_cfg_sdo, o_cfg_shift, o_cfg_latch, o_rb_err;
  logic [N-1:0] o_shadow, o_active;

  inv_cfg_loader #(.NUM_SITES(N), .IDX_W(IW), .INIT(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_idx(i_wr_idx), .i_wr_inv(i_wr_inv), .i_commit(i_commit), .o_busy(o_busy),
    .o_done(o_done), .o_cfg_sdo(o_cfg_sdo), .o_cfg_shift(o_cfg_shift),
    .o_cfg_latch(o_cfg_latch), .i_cfg_sdi(i_cfg_sdi), .o_rb_err(o_rb_err),
    .o_shadow(o_shadow), .o_active(o_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_latch = 0;
  bit chk_en = 1'b0;
  logic cap[$];
  logic [N-1:0] sdi_pat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a load occupies N+1 cycles after commit (N shifting, then one latch).
  int           m_left;
  logic [N-1:0] m_shadow, m_active, m_snap;
  logic         m_rb;

  function automatic logic [N-1:0] apply_wr(input logic [N-1:0] s, input logic v,
                                            input logic [IW-1:0] idx, input logic inv);
    logic [N-1:0] r;
    r = s;
    if (v && int'(idx) < int'(N)) r[idx[2:0]] = inv;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_shadow <= INIT;
      m_active <= INIT;
      m_snap   <= '0;
      m_rb     <= 1'b0;
    end else if (m_left == 0) begin
      m_shadow <= apply_wr(m_shadow, i_wr_valid, i_wr_idx, i_wr_inv);
      if (i_commit) begin
        m_snap <= apply_wr(m_shadow, i_wr_valid, i_wr_idx, i_wr_inv);
        m_left <= N + 1;
        m_rb   <= 1'b0;
      end
    end else begin
      if (RB && m_left >= 2 && i_cfg_sdi != m_active[3'(m_left - 2)]) m_rb <= 1'b1;
      if (m_left == 1) m_active <= m_snap;
      m_left <= m_left - 1;
    end
  end

  // Chain tail returns sdi_pat MSB first during the shift window.
  always @(negedge clk) i_cfg_sdi = (m_left >= 2) ? sdi_pat[3'(m_left - 2)] : 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_cfg_shift) cap.push_back(o_cfg_sdo);
      if (o_cfg_latch) n_latch++;
      if (chk_en) begin
        check("wr_ready", 32'(o_wr_ready), 32'(m_left == 0));
        check("busy", 32'(o_busy), 32'(m_left > 0));
        check("cfg_shift", 32'(o_cfg_shift), 32'(m_left >= 2));
        check("cfg_latch", 32'(o_cfg_latch), 32'(m_left == 1));
        check("done", 32'(o_done), 32'(m_left == 1));
        check("cfg_sdo", 32'(o_cfg_sdo), 32'((m_left >= 2) ? m_snap[3'(m_left - 2)] : 1'b0));
        check("rb_err", 32'(o_rb_err), 32'(m_rb));
        check("shadow", 32'(o_shadow), 32'(m_shadow));
        check("active", 32'(o_active), 32'(m_active));
      end
    end
  end

  task automatic drive(input logic v, input logic [IW-1:0] idx, input logic inv,
                       input logic c);
    @(negedge clk);
    i_wr_valid = v;
    i_wr_idx   = idx;
    i_wr_inv   = inv;
    i_commit   = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] cap_val();
    logic [31:0] v;
    v = '0;
    foreach (cap[i]) v = {v[30:0], cap[i]};
    return v;
  endfunction

  int lat0;

  initial begin
    rst_n = 1'b1;
    i_wr_valid = 1'b0; i_wr_idx = '0; i_wr_inv = 1'b0; i_commit = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_shadow", 32'(o_shadow), 32'h00);
    check("rst_active", 32'(o_active), 32'h00);
    check("rst_wr_ready", 32'(o_wr_ready), 32'h1);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_cfg", {28'h0, o_cfg_sdo, o_cfg_shift, o_cfg_latch, o_done}, 32'h0);
    check("rst_rb_err", 32'(o_rb_err), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Basic load of sites 0 and 5.
    drive(1'b1, 4'd0, 1'b1, 1'b0);
    drive(1'b1, 4'd5, 1'b1, 1'b0);
    idle(1);
    check("shadow_after_wr", 32'(o_shadow), 32'h21);
    cap.delete(); lat0 = n_latch; sdi_pat = 8'h00;
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(N + 2);
    #1;
    check("load1_len", cap.size(), 32'd8);
    check("load1_bits", cap_val(), 32'h21);
    check("load1_latches", n_latch - lat0, 32'd1);
    check("load1_active", 32'(o_active), 32'h21);

    // Out-of-range index is accepted and dropped.
    drive(1'b1, 4'd9, 1'b1, 1'b0);
    idle(1);
    check("oor_shadow", 32'(o_shadow), 32'h21);
    cap.delete(); sdi_pat = 8'h21;
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(N + 2);
    #1;
    check("load2_bits", cap_val(), 32'h21);

    // Same-cycle write joins the snapshot; a commit during SHIFT is ignored.
    lat0 = n_latch;
    drive(1'b1, 4'd2, 1'b1, 1'b1);
    idle(2);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(N + 4);
    #1;
    check("same_cyc_active", 32'(o_active), 32'h25);
    check("no_second_load", n_latch - lat0, 32'd1);

    // Readback: clean load to 8'h21, then a load of 8'h00 against a wrong tail.
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    sdi_pat = 8'h25;
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(N + 2);
    #1;
    check("rb_clean_active", 32'(o_active), 32'h21);
    check("rb_clean_err", 32'(o_rb_err), 32'h0);
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    sdi_pat = 8'h20;
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(N + 2);
    #1;
    check("rb_bad_active", 32'(o_active), 32'h00);
    check("rb_bad_err", 32'(o_rb_err), RB ? 32'h1 : 32'h0);
    sdi_pat = 8'h00;
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    #1;
    check("rb_clr_entry", 32'(o_rb_err), 32'h0);
    idle(N + 1);
    #1;
    check("rb_clr_after", 32'(o_rb_err), 32'h0);

    // Commit held through LATCH starts a second load immediately.
    lat0 = n_latch;
    drive(1'b1, 4'd7, 1'b1, 1'b1);
    repeat (N + 2) drive(1'b0, '0, 1'b0, 1'b1);
    idle(N + 3);
    #1;
    check("b2b_latches", n_latch - lat0, 32'd2);
    check("b2b_active", 32'(o_active), 32'h80);

    // Reset in the 4th SHIFT cycle aborts the load.
    drive(1'b1, 4'd3, 1'b1, 1'b1);
    idle(3);
    @(posedge clk);
    #1;
    check("pre_abort_shift", 32'(o_cfg_shift), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(o_busy), 32'h0);
    check("abort_shift", 32'(o_cfg_shift), 32'h0);
    check("abort_latch", 32'(o_cfg_latch), 32'h0);
    check("abort_shadow", 32'(o_shadow), 32'h00);
    check("abort_active", 32'(o_active), 32'h00);
    lat0 = n_latch;
    @(negedge clk);
    rst_n = 1'b1;
    idle(N + 4);
    #1;
    check("abort_no_latch", n_latch - lat0, 32'd0);
    check("abort_active_hold", 32'(o_active), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: bench did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inv_cfg_loader.md
Name: inv_cfg_loader

Overview:
- Configuration controller for a row of NUM_SITES cells that each carry one invertible input pin (INV_A style per-site inversion bit).
- Collects per-site inversion writes into a shadow register, then on commit shifts the whole vector serially into the external config chain and pulses a latch.
- Sits between the fabric config bus and the site config chain; it is the only writer of site inversion state.

Parameters:
- NUM_SITES, 8, number of invertible sites in the chain (range 2..64).
- IDX_W, 3, width of the site index; must be >= clog2(NUM_SITES).
- INIT, {NUM_SITES{1'b0}}, reset value of the shadow and active vectors (bit i = site i inverted).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset, released synchronously outside this block.
- wr_valid  in  1  per-site write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_idx  in  IDX_W  site index.
- wr_inv  in  1  new inversion bit for site wr_idx.
- commit  in  1  start a load of the shadow vector into the chain.
- busy  out  1  high in SHIFT and LATCH.
- done  out  1  one-cycle pulse, coincident with cfg_latch.
- cfg_sdo  out  1  serial data to chain head.
- cfg_shift  out  1  chain shift enable.
- cfg_latch  out  1  one-cycle chain update strobe.
- cfg_sdi  in  1  serial data from chain tail (used only with the optional feature).
- rb_err  out  1  readback mismatch flag (optional feature).
- shadow  out  NUM_SITES  pending configuration.
- active  out  NUM_SITES  last committed configuration.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; shadow=active=INIT; bit counter=0; busy, done, cfg_sdo, cfg_shift, cfg_latch, rb_err all 0. Reset mid-SHIFT/LATCH aborts the load with no latch pulse. Chain contents are then undefined until the next commit.
- FSM states IDLE, SHIFT, LATCH.
- IDLE: wr_ready=1.
  - Write with wr_idx < NUM_SITES sets shadow[wr_idx]=wr_inv.
  - Write with wr_idx >= NUM_SITES is accepted and dropped.
  - commit=1 snapshots shadow into the shift register and moves to SHIFT. A same-cycle write is applied before the snapshot and is included.
- SHIFT: wr_ready=0. Lasts exactly NUM_SITES cycles with cfg_shift=1.
  - cfg_sdo presents site NUM_SITES-1 in the first cycle and site 0 in the last (MSB first).
  - The counter counts 0..NUM_SITES-1, then the FSM goes to LATCH.
- LATCH: one cycle; cfg_latch=1, done=1, cfg_shift=0. active<=snapshot at the end of the cycle. Next state IDLE.
- Latency: commit sampled at edge T → cfg_shift high for cycles T+1..T+NUM_SITES → cfg_latch/done high in cycle T+NUM_SITES+1 → wr_ready high again in cycle T+NUM_SITES+2.
- commit while busy is ignored (not queued). wr_valid while busy stalls (wr_ready=0); the requester holds its request.
- All outputs are registered. cfg_sdo=0 whenever cfg_shift=0.
- Back-to-back commit: commit held high through LATCH starts a new load in the first IDLE cycle.

Optional Feature:
- Macro: INV_CFG_READBACK_EN.
- Defined: during SHIFT, cfg_sdi returns the previous chain contents, MSB first. Each bit is compared with the corresponding bit of active (pre-update).
  - Any mismatch sets rb_err, which is sticky.
  - rb_err clears at the start of the next commit (entry to SHIFT) or on reset.
  - First load after reset compares against INIT.
- Not defined: cfg_sdi is ignored and rb_err is tied to 0; no compare logic is synthesised.

Test Plan:
- Reset, NUM_SITES=8, INIT=0 → shadow=active=8'h00, wr_ready=1, busy=0, all cfg_* outputs 0.
- Write idx 0 inv=1, idx 5 inv=1, then commit → cfg_shift high 8 cycles with cfg_sdo sequence 0,0,1,0,0,0,0,1, then cfg_latch=done=1 for one cycle, active=8'h21.
- Write idx 9 inv=1 then commit → write accepted, shadow unchanged 8'h21, shifted pattern equals 8'h21.
- commit and write idx 2 inv=1 in the same IDLE cycle → active=8'h25 after latch. A second commit pulsed during SHIFT produces no second load.
- Assert rst_n low at the 4th SHIFT cycle → immediate busy=0, cfg_shift=0, no cfg_latch, shadow=active=INIT.
- With INV_CFG_READBACK_EN: active=8'h21, commit 8'h00 while cfg_sdi returns 8'h20 → rb_err=1 after SHIFT. Next commit with correct readback → rb_err cleared at SHIFT entry and stays 0.
